sram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for one single-port synchronous SRAM (cs/we/ad/din/dout, write when cs&we, read data registered on the same edge). After reset, or on a clear request, it sweeps the SRAM and writes zero to every word. It then grants one request per cycle to port 0 or port 1 using round-robin arbitration and returns read data to the requester that issued the read. It sits between two bus-side masters and the SRAM macro.

---
 rtl/sram_arbiter.sv | 71 +++++++
 tb/tb_sram_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: zero-fill sequencer and round-robin two-port arbiter for one single-port SRAM
// Ports: clk, rst_n (async, active low), clr (restart zero-fill);
//   per port x in {0,1}: reqx/wex/adx/dinx in, gntx/rvalidx out; shared rdata out;
//   init_done out; sram_cs/sram_we/sram_ad/sram_din to the macro, sram_dout back from it.
module sram_arbiter #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [DEPTH_LOG-1:0] ad0,
  input  logic [WIDTH-1:0]     din0,
  output logic                 gnt0,
  output logic                 rvalid0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [DEPTH_LOG-1:0] ad1,
  input  logic [WIDTH-1:0]     din1,
  output logic                 gnt1,
  output logic                 rvalid1,
  output logic [WIDTH-1:0]     rdata,
  output logic                 init_done,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [DEPTH_LOG-1:0] sram_ad,
  output logic [WIDTH-1:0]     sram_din,
  input  logic [WIDTH-1:0]     sram_dout
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [DEPTH_LOG-1:0] cnt, cnt_nx;
  logic rr_last, rd_pend, rd_tag;
  logic run, pick1, last;
  always_comb begin
    run = state == RUN && !clr;
    // port 1 wins when alone, or when contended and port 0 was served last
    pick1 = req1 && (!req0 || !rr_last);
    gnt0 = run && req0 && !pick1;
    gnt1 = run && pick1;
    init_done = state == RUN;
    sram_cs = state == INIT || gnt0 || gnt1;
    sram_we = state == INIT || (gnt0 ? we0 : gnt1 && we1);
    sram_ad = state == INIT ? cnt : gnt0 ? ad0 : gnt1 ? ad1 : '0;
    sram_din = gnt0 ? din0 : gnt1 ? din1 : '0;
    rvalid0 = rd_pend && !rd_tag;
    rvalid1 = rd_pend && rd_tag;
    rdata = rd_pend ? sram_dout : '0;
    last = cnt == DEPTH_LOG'(DEPTH - 1);
    state_nx = state == INIT ? (last && !clr ? RUN : INIT) : (clr ? INIT : RUN);
    // the counter only moves while sweeping and rests at zero otherwise
    cnt_nx = state == INIT && !clr && !last ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
      rr_last <= 1'b1;
      rd_pend <= 1'b0;
      rd_tag <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (gnt0 || gnt1) rr_last <= gnt1;
      rd_pend <= (gnt0 && !we0) || (gnt1 && !we1);
      rd_tag <= gnt1;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed checks of sram_arbiter against a behavioural model
module tb_sram_arbiter;
  localparam int DEPTH = 8, WIDTH = 32, AW = 3;
  logic clk = 0, rst_n = 1, clr = 0;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [AW-1:0] ad0 = '0, ad1 = '0;
  logic [WIDTH-1:0] din0 = '0, din1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, init_done, sram_cs, sram_we;
  logic [AW-1:0] sram_ad;
  logic [WIDTH-1:0] rdata, sram_din, sram_dout;
  logic [WIDTH-1:0] mem [DEPTH];
  int checks = 0, errors = 0;
  logic [WIDTH-1:0] mem_m [DEPTH];
  logic [WIDTH-1:0] erd = '0;
  int prio = 0;
  bit run_m = 0, eg0 = 0, eg1 = 0, erv0 = 0, erv1 = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .req0(req0), .we0(we0), .ad0(ad0), .din0(din0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .ad1(ad1), .din1(din1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .init_done(init_done),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_ad(sram_ad), .sram_din(sram_din),
    .sram_dout(sram_dout)
  );

  always @(posedge clk)
    if (sram_cs) begin
      if (sram_we) mem[sram_ad] <= sram_din;
      else sram_dout <= mem[sram_ad];
    end

  // prio names the port that wins the next contended cycle
  task automatic predict();
    eg0 = run_m && !clr && req0 && (!req1 || prio == 0);
    eg1 = run_m && !clr && req1 && (!req0 || prio == 1);
  endtask

  task automatic commit();
    bit n0 = 0, n1 = 0;
    if (eg0) begin
      if (we0) mem_m[ad0] = din0;
      else begin n0 = 1; erd = mem_m[ad0]; end
      prio = 1;
    end
    if (eg1) begin
      if (we1) mem_m[ad1] = din1;
      else begin n1 = 1; erd = mem_m[ad1]; end
      prio = 0;
    end
    erv0 = n0;
    erv1 = n1;
  endtask

  task automatic tick();
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      predict();
      checks++;
      if ({sram_cs, sram_we, sram_ad, sram_din, init_done, gnt0, gnt1, rvalid0, rvalid1} !==
          {1'b1, 1'b1, AW'(i), 32'h0, 5'b0})
        $display("FAIL sweep%0d: got cs=%b we=%b ad=%0d din=%h done=%b gnt=%b%b rv=%b%b expected 1 1 %0d 0 0 00 00",
                 i, sram_cs, sram_we, sram_ad, sram_din, init_done, gnt0, gnt1, rvalid0, rvalid1, i);
      if ({sram_cs, sram_we, sram_ad, sram_din, init_done, gnt0, gnt1, rvalid0, rvalid1} !==
          {1'b1, 1'b1, AW'(i), 32'h0, 5'b0}) errors++;
      tick();
    end
    run_m = 1;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    req0 = 1; we0 = 0; ad0 = 3'd2;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, init_done, rdata} !== 37'b0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b done=%b rdata=%h expected all zero",
               gnt0, gnt1, rvalid0, rvalid1, init_done, rdata);
    end
    @(posedge clk);
    #1 rst_n = 1;
    run_m = 0; prio = 0; erv0 = 0; erv1 = 0;
    test_sweep();
    @(negedge clk);
    predict();
    checks++;
    if ({init_done, gnt0, gnt1} !== 3'b110) begin
      errors++;
      $display("FAIL first_run_cycle: got done=%b gnt=%b%b expected 1 10", init_done, gnt0, gnt1);
    end
    tick();
    req0 = 0;
    @(negedge clk);
    predict();
    checks++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL first_read: got rv=%b%b rdata=%h expected 10 00000000", rvalid0, rvalid1, rdata);
    end
    tick();
  endtask

  task automatic test_write_read();
    req0 = 1; we0 = 1; ad0 = 3'd3; din0 = 32'hDEADBEEF;
    @(negedge clk);
    predict();
    checks++;
    if ({gnt0, gnt1, sram_cs, sram_we, sram_ad, sram_din} !== {4'b1011, 3'd3, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL write_grant: got gnt=%b%b cs=%b we=%b ad=%0d din=%h expected 10 1 1 3 deadbeef",
               gnt0, gnt1, sram_cs, sram_we, sram_ad, sram_din);
    end
    tick();
    we0 = 0;
    @(negedge clk);
    predict();
    checks++;
    if ({gnt0, gnt1, sram_cs, sram_we, sram_ad} !== {4'b1010, 3'd3}) begin
      errors++;
      $display("FAIL read_grant: got gnt=%b%b cs=%b we=%b ad=%0d expected 10 1 0 3",
               gnt0, gnt1, sram_cs, sram_we, sram_ad);
    end
    tick();
    req0 = 0;
    @(negedge clk);
    predict();
    checks++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL read_return: got rv=%b%b rdata=%h expected 10 deadbeef", rvalid0, rvalid1, rdata);
    end
    tick();
  endtask

  task automatic test_req1_only();
    for (int k = 0; k < 4; k++) begin
      req1 = 1; we1 = 1; ad1 = AW'(4 + k); din1 = $urandom;
      @(negedge clk);
      predict();
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
        errors++;
        $display("FAIL req1_only%0d: got gnt=%b%b expected 01", k, gnt0, gnt1);
      end
      tick();
    end
  endtask

  task automatic test_contention();
    bit g0;
    req0 = 1; we0 = 0; ad0 = 3'd3;
    req1 = 1; we1 = 0; ad1 = 3'd7;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      predict();
      checks++;
      if ({gnt0, gnt1} !== (i % 2 == 0 ? 2'b10 : 2'b01) || {gnt0, gnt1} !== {eg0, eg1}) begin
        errors++;
        $display("FAIL alternate%0d: got gnt=%b%b expected %b%b", i, gnt0, gnt1, eg0, eg1);
      end
      checks++;
      if ({rvalid0, rvalid1, rdata} !== {erv0, erv1, (erv0 || erv1) ? erd : 32'h0}) begin
        errors++;
        $display("FAIL alt_rdata%0d: got rv=%b%b rdata=%h expected %b%b %h",
                 i, rvalid0, rvalid1, rdata, erv0, erv1, erd);
      end
      g0 = eg0;
      tick();
      if (g0) ad0 = ad0 + 1'b1;
      else ad1 = ad1 - 1'b1;
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    predict();
    checks++;
    if ({rvalid0, rvalid1, rdata} !== {erv0, erv1, erd}) begin
      errors++;
      $display("FAIL alt_drain: got rv=%b%b rdata=%h expected %b%b %h", rvalid0, rvalid1, rdata, erv0, erv1, erd);
    end
    tick();
  endtask

  task automatic test_random();
    bit g0, g1;
    logic [36:0] esram;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      predict();
      checks++;
      if ({gnt0, gnt1} !== {eg0, eg1}) begin
        errors++;
        $display("FAIL rnd_gnt%0d: got %b%b expected %b%b", i, gnt0, gnt1, eg0, eg1);
      end
      checks++;
      if ({rvalid0, rvalid1, rdata} !== {erv0, erv1, (erv0 || erv1) ? erd : 32'h0}) begin
        errors++;
        $display("FAIL rnd_rdata%0d: got rv=%b%b rdata=%h expected %b%b %h",
                 i, rvalid0, rvalid1, rdata, erv0, erv1, erd);
      end
      esram = eg0 ? {1'b1, we0, ad0, din0} : eg1 ? {1'b1, we1, ad1, din1} : 37'b0;
      checks++;
      if ({sram_cs, sram_cs & sram_we, sram_ad, sram_din} !== esram) begin
        errors++;
        $display("FAIL rnd_sram%0d: got cs=%b we=%b ad=%0d din=%h expected %h",
                 i, sram_cs, sram_we, sram_ad, sram_din, esram);
      end
      g0 = eg0; g1 = eg1;
      tick();
      if (g0 || !req0) begin
        req0 = $urandom_range(0, 3) != 0; we0 = 1'($urandom); ad0 = AW'($urandom); din0 = $urandom;
      end
      if (g1 || !req1) begin
        req1 = $urandom_range(0, 3) != 0; we1 = 1'($urandom); ad1 = AW'($urandom); din1 = $urandom;
      end
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    predict();
    checks++;
    if ({rvalid0, rvalid1, rdata} !== {erv0, erv1, (erv0 || erv1) ? erd : 32'h0}) begin
      errors++;
      $display("FAIL rnd_drain: got rv=%b%b rdata=%h expected %b%b %h", rvalid0, rvalid1, rdata, erv0, erv1, erd);
    end
    tick();
  endtask

  task automatic test_clr();
    req0 = 1; we0 = 1; ad0 = 3'd5; din0 = 32'h55;
    @(negedge clk);
    predict();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL clr_write: got gnt=%b%b expected 10", gnt0, gnt1);
    end
    tick();
    we0 = 0;
    @(negedge clk);
    predict();
    tick();
    req1 = 1; we1 = 0; ad1 = 3'd2; clr = 1;
    @(negedge clk);
    predict();
    checks++;
    if ({gnt0, gnt1, sram_cs} !== 3'b000) begin
      errors++;
      $display("FAIL clr_no_grant: got gnt=%b%b cs=%b expected 00 0", gnt0, gnt1, sram_cs);
    end
    checks++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 32'h55}) begin
      errors++;
      $display("FAIL clr_read_return: got rv=%b%b rdata=%h expected 10 00000055", rvalid0, rvalid1, rdata);
    end
    tick();
    clr = 0; req1 = 0; run_m = 0;
    test_sweep();
    @(negedge clk);
    predict();
    checks++;
    if ({init_done, gnt0, gnt1} !== 3'b110) begin
      errors++;
      $display("FAIL clr_resume: got done=%b gnt=%b%b expected 1 10", init_done, gnt0, gnt1);
    end
    tick();
    req0 = 0;
    @(negedge clk);
    predict();
    checks++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL clr_zeroed: got rv=%b%b rdata=%h expected 10 00000000", rvalid0, rvalid1, rdata);
    end
    tick();
  endtask

  task automatic test_reset_midread();
    req0 = 1; we0 = 0; ad0 = 3'd5;
    @(negedge clk);
    predict();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL midread_grant: got gnt=%b%b expected 10", gnt0, gnt1);
    end
    tick();
    req0 = 0; rst_n = 0;
    @(negedge clk);
    checks++;
    if ({rvalid0, rvalid1, init_done, gnt0, gnt1, rdata, sram_ad} !== 40'b0) begin
      errors++;
      $display("FAIL midread_reset: got rv=%b%b done=%b gnt=%b%b rdata=%h ad=%0d expected all zero",
               rvalid0, rvalid1, init_done, gnt0, gnt1, rdata, sram_ad);
    end
    run_m = 0; prio = 0; erv0 = 0; erv1 = 0;
    @(posedge clk);
    #1 rst_n = 1;
    test_sweep();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; ad0 = 3'd1; ad1 = 3'd2;
    @(negedge clk);
    predict();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL reset_priority: got gnt=%b%b expected 10", gnt0, gnt1);
    end
    tick();
    req0 = 0; req1 = 0;
    @(negedge clk);
    predict();
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_req1_only();
    test_contention();
    test_random();
    test_clr();
    test_reset_midread();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
